// File: rtl/exp_pkg.sv
// Shared types and defaults for the divide/sqrt exponent subtractor.
package exp_pkg;

  localparam int unsigned EXP_W      = 13;
  localparam int unsigned TAG_W      = 4;
  localparam int unsigned BIAS_DEF   = 1023;
  localparam int unsigned MAXEXP_DEF = 2046;

  // Op encoding; 2'b11 is reserved and folded onto OP_SUB at the input.
  typedef enum logic [1:0] {
    OP_SUB  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // Payload carried from S1 to S2: raw difference, normalised op, sideband tag.
  typedef struct packed {
    logic signed [EXP_W:0] d;
    op_e                   op;
    logic [TAG_W-1:0]      tag;
  } s1_payload_t;

endpackage

// File: rtl/exp_prefix_sub.sv
// Brent-Kung prefix adder with carry-in: sum = a + b + cin (mod 2^Width).
// The carry-in sits at prefix position 0; bit j's generate/propagate sits at
// position j+1, so the group generate ending at position i is the carry into bit i.
module exp_prefix_sub #(
  parameter int unsigned Width = 14
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             cin,
  output logic [Width-1:0] sum
);

  localparam int unsigned Levels = $clog2(Width);
  localparam int unsigned Stages = 2 * Levels;

  wire [Width-1:0] g [Stages];
  wire [Width-1:0] p [Stages];

  assign g[0][0] = cin;
  assign p[0][0] = 1'b0;

  for (genvar j = 1; j < Width; j++) begin : g_pg
    assign g[0][j] = a[j-1] & b[j-1];
    assign p[0][j] = a[j-1] ^ b[j-1];
  end

  // Up-sweep: grey cell where the combined group reaches position 0, black otherwise.
  for (genvar l = 1; l <= int'(Levels); l++) begin : g_up
    for (genvar i = 0; i < int'(Width); i++) begin : g_node
      if (((i + 1) % (2 ** l)) == 0) begin : g_cell
        assign g[l][i] = g[l-1][i] | (p[l-1][i] & g[l-1][i-2**(l-1)]);
        if ((i + 1) == 2 ** l) begin : g_grey
          assign p[l][i] = 1'b0;
        end else begin : g_black
          assign p[l][i] = p[l-1][i] & p[l-1][i-2**(l-1)];
        end
      end else begin : g_pass
        assign g[l][i] = g[l-1][i];
        assign p[l][i] = p[l-1][i];
      end
    end
  end

  // Down-sweep: every node combines with an already complete prefix, so grey cells only.
  for (genvar l = int'(Levels) - 1; l >= 1; l--) begin : g_down
    localparam int S = 2 * int'(Levels) - l;
    for (genvar i = 0; i < int'(Width); i++) begin : g_node
      if ((((i + 1) % (2 ** l)) == 2 ** (l - 1)) && (i >= 2 ** l)) begin : g_grey
        assign g[S][i] = g[S-1][i] | (p[S-1][i] & g[S-1][i-2**(l-1)]);
        assign p[S][i] = 1'b0;
      end else begin : g_pass
        assign g[S][i] = g[S-1][i];
        assign p[S][i] = p[S-1][i];
      end
    end
  end

  // Sum bits from operand bits and the per-bit carry-in.
  always_comb begin
    sum = a ^ b ^ g[Stages-1];
  end

endmodule

// File: rtl/exp_sub_pipe.sv
// Two-stage exponent subtractor: S1 forms A - B', S2 adds the bias back and flags.
module exp_sub_pipe
  import exp_pkg::*;
#(
  parameter int unsigned W      = EXP_W,
  parameter int unsigned BIAS   = BIAS_DEF,
  parameter int unsigned MAXEXP = MAXEXP_DEF,
  parameter int unsigned TAGW   = TAG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Flush,
  input  logic                InValid,
  output logic                InReady,
  input  logic [1:0]          Op,
  input  logic [W-1:0]        ExpA,
  input  logic [W-1:0]        ExpB,
  input  logic [TAGW-1:0]     TagIn,
  output logic                OutValid,
  input  logic                OutReady,
  output logic signed [W:0]   ExpOut,
  output logic                Ovf,
  output logic                Unf,
  output logic                Neg,
  output logic [TAGW-1:0]     TagOut
);

  // Signed constants so the S2 add and compare stay signed end to end.
  localparam logic signed [W:0] BiasS   = $signed((W + 1)'(BIAS));
  localparam logic signed [W:0] MaxExpS = $signed((W + 1)'(MAXEXP));

  op_e               op_norm;
  logic [W-1:0]      b_sel;
  logic [W:0]        d_raw;
  s1_payload_t       s1_d, s1_q;
  logic              v1_q, v2_q;
  logic              ready1, ready2;
  logic signed [W:0] d1;
  logic signed [W:0] r_d;
  logic              is_sub, neg_d, unf_d, ovf_d;
  logic signed [W:0] exp_q;
  logic              ovf_q, unf_q, neg_q;
  logic [TAGW-1:0]   tag_q;

  // S1 operand selection: reserved op folds onto SUB, SQRT subtracts the bias.
  always_comb begin
    op_norm = OP_SUB;
    unique case (Op)
      2'b01:   op_norm = OP_DIV;
      2'b10:   op_norm = OP_SQRT;
      default: op_norm = OP_SUB;
    endcase
    b_sel = (op_norm == OP_SQRT) ? W'(BIAS) : ExpB;
  end

  exp_prefix_sub #(
    .Width(W + 1)
  ) u_prefix_sub (
    .a  ({1'b0, ExpA}),
    .b  (~{1'b0, b_sel}),
    .cin(1'b1),
    .sum(d_raw)
  );

  // S1 payload assembly.
  always_comb begin
    s1_d.d   = d_raw;
    s1_d.op  = op_norm;
    s1_d.tag = TagIn;
  end

  // S2 result and flags; SQRT halves with floor before re-biasing.
  always_comb begin
    d1     = s1_q.d;
    r_d    = d1;
    unique case (s1_q.op)
      OP_DIV:  r_d = d1 + BiasS;
      OP_SQRT: r_d = (d1 >>> 1) + BiasS;
      default: r_d = d1;
    endcase
    is_sub = (s1_q.op == OP_SUB) || (s1_q.op == OP_RSVD);
    neg_d  = r_d[W];
    unf_d  = ~is_sub & (neg_d | (r_d == '0));
    ovf_d  = ~is_sub & ~neg_d & (r_d > MaxExpS);
  end

  // Handshake: a stage can take new data when empty or when the stage after it moves.
  always_comb begin
    ready2  = ~v2_q | OutReady;
    ready1  = ~v1_q | ready2;
    InReady = ready1 & ~Flush;
  end

  // Stage valids; reset beats flush, flush beats any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (Flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      if (ready2) v2_q <= v1_q;
      if (ready1) v1_q <= InValid;
    end
  end

  // Stage data; only loaded when a valid op moves in, so held results stay stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= '0;
      exp_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      neg_q <= 1'b0;
      tag_q <= '0;
    end else if (!Flush) begin
      if (ready2 && v1_q) begin
        exp_q <= r_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        neg_q <= neg_d;
        tag_q <= s1_q.tag;
      end
      if (ready1 && InValid) s1_q <= s1_d;
    end
  end

  // Output mapping.
  always_comb begin
    OutValid = v2_q;
    ExpOut   = exp_q;
    Ovf      = ovf_q;
    Unf      = unf_q;
    Neg      = neg_q;
    TagOut   = tag_q;
  end

endmodule

// File: tb/tb_exp_sub_pipe.sv
// Directed and randomized checks of exp_sub_pipe against an arithmetic reference model.
module tb_exp_sub_pipe;

  localparam int W    = 13;
  localparam int TAGW = 4;

  logic                clk = 1'b0;
  logic                reset, Flush, InValid, InReady, OutValid, OutReady;
  logic                Ovf, Unf, Neg;
  logic [1:0]          Op;
  logic [W-1:0]        ExpA, ExpB;
  logic [TAGW-1:0]     TagIn, TagOut;
  logic signed [W:0]   ExpOut;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  typedef struct {
    logic [W:0]      e;
    logic            ovf;
    logic            unf;
    logic            neg;
    logic [TAGW-1:0] tag;
  } res_t;

  res_t sb[$];
  res_t held;
  logic hold_pend = 1'b0;

  always #5 clk = ~clk;

  exp_sub_pipe dut (
    .clk     (clk),
    .reset   (reset),
    .Flush   (Flush),
    .InValid (InValid),
    .InReady (InReady),
    .Op      (Op),
    .ExpA    (ExpA),
    .ExpB    (ExpB),
    .TagIn   (TagIn),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .ExpOut  (ExpOut),
    .Ovf     (Ovf),
    .Unf     (Unf),
    .Neg     (Neg),
    .TagOut  (TagOut)
  );

  function automatic logic [W:0] e(input int v);
    return v[W:0];
  endfunction

  // Reference: plain integer arithmetic on the exponent rules.
  function automatic res_t model(input logic [1:0] op, input int a, input int b,
                                 input logic [TAGW-1:0] tag);
    int   d, r;
    res_t x;
    logic nonsub;
    nonsub = (op == 2'b01) || (op == 2'b10);
    if (op == 2'b10) begin
      d = a - 1023;
      if (d >= 0) r = d / 2;
      else        r = -((1 - d) / 2);
      r = r + 1023;
    end else if (op == 2'b01) begin
      r = a - b + 1023;
    end else begin
      r = a - b;
    end
    x.e   = r[W:0];
    x.neg = (r < 0);
    x.unf = nonsub && (r <= 0);
    x.ovf = nonsub && (r > 2046);
    x.tag = tag;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input int a, input int b,
                       input logic [TAGW-1:0] tag, input logic ordy, input logic fl,
                       input logic rst);
    InValid  = v;
    Op       = op;
    ExpA     = a[W-1:0];
    ExpB     = b[W-1:0];
    TagIn    = tag;
    OutReady = ordy;
    Flush    = fl;
    reset    = rst;
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 2'b00, 0, 0, '0, ordy, 1'b0, 1'b0);
  endtask

  // Scoreboard bookkeeping for the current cycle, then advance one clock.
  task automatic tick();
    res_t want;
    if (hold_pend) begin
      chk("hold_valid", OutValid, 1);
      chk("hold_exp", 32'($unsigned(ExpOut)), 32'(held.e));
      chk("hold_flags", {Ovf, Unf, Neg}, {held.ovf, held.unf, held.neg});
      chk("hold_tag", TagOut, held.tag);
    end
    hold_pend = 1'b0;
    if (reset) begin
      sb.delete();
    end else begin
      if (OutValid && OutReady) begin
        chk("out_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          want = sb.pop_front();
          pops++;
          chk("sb_exp", 32'($unsigned(ExpOut)), 32'(want.e));
          chk("sb_ovf", Ovf, want.ovf);
          chk("sb_unf", Unf, want.unf);
          chk("sb_neg", Neg, want.neg);
          chk("sb_tag", TagOut, want.tag);
        end
      end else if (OutValid && !Flush) begin
        hold_pend  = 1'b1;
        held.e     = $unsigned(ExpOut);
        held.ovf   = Ovf;
        held.unf   = Unf;
        held.neg   = Neg;
        held.tag   = TagOut;
      end
      if (InValid && InReady) sb.push_back(model(Op, int'(ExpA), int'(ExpB), TagIn));
      if (Flush) sb.delete();
    end
    @(posedge clk);
    #2;
  endtask

  // Present one op until accepted (bounded).
  task automatic send(input logic [1:0] op, input int a, input int b,
                      input logic [TAGW-1:0] tag, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      drive(1'b1, op, a, b, tag, ordy, 1'b0, 1'b0);
      acc = InReady;
      tick();
    end
    chk("send_accept", acc, 1);
    InValid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    logic [1:0] rop;

    // Reset state
    drive(1'b0, 2'b00, 0, 0, '0, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    idle(1'b1);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_exp", 32'($unsigned(ExpOut)), 0);
    chk("rst_flags", {Ovf, Unf, Neg}, 0);
    chk("rst_tag", TagOut, 0);
    chk("rst_inready", InReady, 1);

    // 1: DIV latency and value
    send(2'b01, 1028, 1025, 4'd5, 1'b1);
    idle(1'b1);
    chk("t1_lat1_valid", OutValid, 0);
    tick();
    idle(1'b1);
    chk("t1_valid", OutValid, 1);
    chk("t1_exp", 32'($unsigned(ExpOut)), 32'(e(1026)));
    chk("t1_flags", {Ovf, Unf, Neg}, 0);
    chk("t1_tag", TagOut, 5);
    tick();

    // 2: DIV overflow and underflow
    send(2'b01, 2046, 1, 4'd6, 1'b1);
    send(2'b01, 1, 2046, 4'd7, 1'b1);
    idle(1'b1);
    chk("t2_ovf_exp", 32'($unsigned(ExpOut)), 32'(e(3068)));
    chk("t2_ovf_flags", {Ovf, Unf, Neg}, 3'b100);
    tick();
    idle(1'b1);
    chk("t2_unf_exp", 32'($unsigned(ExpOut)), 32'(e(-1022)));
    chk("t2_unf_flags", {Ovf, Unf, Neg}, 3'b011);
    tick();

    // 3: SQRT rounding and SUB / reserved op
    send(2'b10, 1032, 0, 4'd1, 1'b1);
    send(2'b10, 1020, 0, 4'd2, 1'b1);
    idle(1'b1);
    chk("t3_sqrt_exp", 32'($unsigned(ExpOut)), 32'(e(1027)));
    tick();
    idle(1'b1);
    chk("t3_sqrt_floor_exp", 32'($unsigned(ExpOut)), 32'(e(1021)));
    tick();
    send(2'b00, 5, 9, 4'd3, 1'b1);
    idle(1'b1);
    tick();
    idle(1'b1);
    chk("t3_sub_exp", 32'($unsigned(ExpOut)), 32'(e(-4)));
    chk("t3_sub_flags", {Ovf, Unf, Neg}, 3'b001);
    tick();
    send(2'b11, 5, 9, 4'd4, 1'b1);
    idle(1'b1);
    tick();
    idle(1'b1);
    chk("t3_rsvd_exp", 32'($unsigned(ExpOut)), 32'(e(-4)));
    chk("t3_rsvd_flags", {Ovf, Unf, Neg}, 3'b001);
    chk("t3_rsvd_tag", TagOut, 4);
    tick();

    // 4: backpressure
    p0 = pops;
    drive(1'b1, 2'b01, 1100, 1000, 4'd8, 1'b0, 1'b0, 1'b0);
    chk("t4_acc0", InReady, 1);
    tick();
    drive(1'b1, 2'b01, 1200, 1000, 4'd9, 1'b0, 1'b0, 1'b0);
    chk("t4_acc1", InReady, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b01, 1300, 1000, 4'd10, 1'b0, 1'b0, 1'b0);
      chk("t4_full_inready", InReady, 0);
      chk("t4_held_exp", 32'($unsigned(ExpOut)), 32'(e(1123)));
      tick();
    end
    send(2'b01, 1300, 1000, 4'd10, 1'b1);
    send(2'b01, 1400, 1000, 4'd11, 1'b1);
    for (int k = 0; k < 6; k++) begin
      idle(1'b1);
      tick();
    end
    chk("t4_emitted", pops - p0, 4);
    chk("t4_drained", sb.size(), 0);

    // 5: flush with both stages full and a coincident input
    drive(1'b1, 2'b00, 100, 50, 4'd12, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b00, 200, 50, 4'd13, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b00, 300, 50, 4'd14, 1'b1, 1'b1, 1'b0);
    chk("t5_flush_inready", InReady, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      chk("t5_after_flush_valid", OutValid, 0);
      tick();
    end

    // 6: reset with both stages full, then a fresh op
    drive(1'b1, 2'b01, 1500, 1000, 4'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b01, 1600, 1000, 4'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b01, 1700, 1000, 4'd4, 1'b1, 1'b0, 1'b1);
    tick();
    idle(1'b1);
    chk("t6_valid", OutValid, 0);
    chk("t6_exp", 32'($unsigned(ExpOut)), 0);
    chk("t6_flags", {Ovf, Unf, Neg}, 0);
    chk("t6_tag", TagOut, 0);
    chk("t6_inready", InReady, 1);
    send(2'b01, 1028, 1025, 4'd15, 1'b1);
    idle(1'b1);
    chk("t6_lat1_valid", OutValid, 0);
    tick();
    idle(1'b1);
    chk("t6_new_valid", OutValid, 1);
    chk("t6_new_exp", 32'($unsigned(ExpOut)), 32'(e(1026)));
    chk("t6_new_tag", TagOut, 15);
    tick();

    // Randomized traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      rop = 2'($urandom_range(0, 3));
      drive(($urandom_range(0, 3) != 0), rop, $urandom_range(0, 4095),
            $urandom_range(0, 4095), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 99) == 0));
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      idle(1'b1);
      tick();
    end
    chk("final_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
